// File: rtl/trivium_byte_loader.sv
// Byte-command front end for the Trivium cipher: collects key/IV from the UART byte stream,
// kicks off cipher initialisation and forwards plaintext bytes through a one-byte valid/ready buffer.
module trivium_byte_loader #(
    parameter int unsigned KEY_BYTES = 10,
    parameter int unsigned IV_BYTES  = 10,
    parameter logic [7:0]  CMD_KEY   = 8'h4B,
    parameter logic [7:0]  CMD_DATA  = 8'h44
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_enable,
    output logic [8*KEY_BYTES-1:0] key,
    output logic [8*IV_BYTES-1:0]  iv,
    output logic                   init_start,
    input  logic                   init_busy,
    output logic [7:0]             pt_data,
    output logic                   pt_valid,
    input  logic                   pt_ready,
    output logic                   key_loaded,
    output logic [1:0]             status
);

    localparam int unsigned   MAXB     = (KEY_BYTES > IV_BYTES) ? KEY_BYTES : IV_BYTES;
    localparam int unsigned   CW       = $clog2(MAXB + 1);
    localparam logic [CW-1:0] KEY_LAST = CW'(KEY_BYTES - 1);
    localparam logic [CW-1:0] IV_LAST  = CW'(IV_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_IV,
        S_INIT,
        S_LEN,
        S_DATA
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   byte_cnt;
    logic [7:0]      cnt;
    logic [1:0]      init_cnt;
    logic            accept;
    logic            overrun;

    assign accept = pt_valid && pt_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rx_enable = 1'b1;
        overrun   = 1'b0;
        case (state)
            S_IDLE: begin
                if (rx_valid) begin
                    if (rx_data == CMD_KEY) begin
                        state_nxt = S_KEY;
                    end else if (rx_data == CMD_DATA && key_loaded) begin
                        state_nxt = S_LEN;
                    end
                end
            end
            S_KEY: begin
                if (rx_valid && byte_cnt == KEY_LAST) begin
                    state_nxt = S_IV;
                end
            end
            S_IV: begin
                if (rx_valid && byte_cnt == IV_LAST) begin
                    state_nxt = S_INIT;
                end
            end
            S_INIT: begin
                rx_enable = 1'b0;
                overrun   = rx_valid;
                // init_busy is only trusted once the cipher has had two cycles to raise it
                if (init_cnt == 2'd2 && !init_busy) begin
                    state_nxt = S_IDLE;
                end
            end
            S_LEN: begin
                if (rx_valid) begin
                    state_nxt = (rx_data == 8'd0) ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                rx_enable = !pt_valid;
                overrun   = rx_valid && pt_valid && !pt_ready;
                if (accept && cnt == 8'd1) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key        <= '0;
            iv         <= '0;
            byte_cnt   <= '0;
            cnt        <= '0;
            init_cnt   <= '0;
            init_start <= 1'b0;
            pt_data    <= '0;
            pt_valid   <= 1'b0;
            key_loaded <= 1'b0;
            status     <= '0;
        end else begin
            init_start <= 1'b0;
            if (overrun) begin
                status[0] <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == CMD_KEY) begin
                            key_loaded <= 1'b0;
                            status[0]  <= 1'b0;
                            byte_cnt   <= '0;
                        end else if (rx_data == CMD_DATA && !key_loaded) begin
                            status[1] <= 1'b1;
                        end
                    end
                end
                S_KEY: begin
                    if (rx_valid) begin
                        key      <= {key[8*KEY_BYTES-9:0], rx_data};
                        byte_cnt <= (byte_cnt == KEY_LAST) ? '0 : byte_cnt + 1'b1;
                    end
                end
                S_IV: begin
                    if (rx_valid) begin
                        iv <= {iv[8*IV_BYTES-9:0], rx_data};
                        if (byte_cnt == IV_LAST) begin
                            byte_cnt   <= '0;
                            init_cnt   <= '0;
                            init_start <= 1'b1;
                        end else begin
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                S_INIT: begin
                    if (init_cnt != 2'd2) begin
                        init_cnt <= init_cnt + 2'd1;
                    end else if (!init_busy) begin
                        key_loaded <= 1'b1;
                    end
                end
                S_LEN: begin
                    if (rx_valid) begin
                        cnt <= rx_data;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        cnt <= cnt - 8'd1;
                        // a byte arriving with the handshake refills the buffer directly
                        if (rx_valid && cnt != 8'd1) begin
                            pt_data <= rx_data;
                        end else begin
                            pt_valid <= 1'b0;
                        end
                    end else if (rx_valid && !pt_valid) begin
                        pt_data  <= rx_data;
                        pt_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
